// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode/state enums and instruction field slicing for cpu_controller_param
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LDI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_JNZ  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_HALTED
  } state_e;

  localparam int OP_W = 3;

  // Instructions are passed zero-extended to 32 bits so one set of helpers serves every RIDX_W.
  function automatic op_e get_op(input logic [31:0] inst, input int inst_w);
    return op_e'(3'(inst >> (inst_w - OP_W)));
  endfunction

  function automatic logic [7:0] get_field(input logic [31:0] inst, input int pos,
                                           input int ridx_w);
    logic [31:0] mask;
    mask = (32'd1 << ridx_w) - 32'd1;
    return 8'((inst >> (pos * ridx_w)) & mask);
  endfunction

  function automatic logic [7:0] get_rd(input logic [31:0] inst, input int ridx_w);
    return get_field(inst, 2, ridx_w);
  endfunction

  function automatic logic [7:0] get_ra(input logic [31:0] inst, input int ridx_w);
    return get_field(inst, 1, ridx_w);
  endfunction

  function automatic logic [7:0] get_rb(input logic [31:0] inst, input int ridx_w);
    return get_field(inst, 0, ridx_w);
  endfunction

endpackage

// File: rtl/alu_param.sv
// rtl/alu_param.sv - combinational ALU for cpu_controller_param
module alu_param
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/cpu_controller_param.sv
// rtl/cpu_controller_param.sv - step/run CPU controller with loadable imem and register file
module cpu_controller_param
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int RIDX_W  = 3,
  parameter int IMEM_AW = 3,
  localparam int INST_W = 3 + 3 * RIDX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INST_W-1:0]  external,
  input  logic [IMEM_AW-1:0] ext_inst_addr,
  input  logic [DATA_W-1:0]  external_reg_file_data,
  input  logic [RIDX_W-1:0]  external_reg_file_index,
  input  logic               is_external,
  input  logic               load_to_inst_mem,
  input  logic               load_to_reg_file,
  input  logic               next_inst,
  input  logic               run_mode,
  output logic               busy,
  output logic               halted,
  output logic [IMEM_AW-1:0] pc,
  output logic [3:0][3:0]    display_out
);

  localparam int NREG   = 2 ** RIDX_W;
  localparam int IDEPTH = 2 ** IMEM_AW;

  state_e              state_q, state_d;
  logic [IMEM_AW-1:0]  pc_q, pc_d;
  logic [INST_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [RIDX_W-1:0]   last_rd_q, last_rd_d;
  logic                btn_prev_q;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [INST_W-1:0]   imem_q [IDEPTH];

  op_e                 op;
  logic [RIDX_W-1:0]   rd, ra, rb;
  logic [2*RIDX_W-1:0] imm;
  logic [DATA_W-1:0]   alu_y, wb_data;
  logic                writes_reg, wb_en, btn_rise, load_ok;

  assign op  = get_op(32'(ir_q), INST_W);
  assign rd  = RIDX_W'(get_rd(32'(ir_q), RIDX_W));
  assign ra  = RIDX_W'(get_ra(32'(ir_q), RIDX_W));
  assign rb  = RIDX_W'(get_rb(32'(ir_q), RIDX_W));
  assign imm = {ra, rb};

  assign btn_rise   = next_inst & ~btn_prev_q;
  assign load_ok    = (state_q == ST_IDLE) || (state_q == ST_HALTED);
  assign writes_reg = (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
                      (op == OP_AND) || (op == OP_OR);
  assign wb_en      = (state_q == ST_EXEC) && writes_reg;
  assign wb_data    = (op == OP_LDI) ? DATA_W'(imm) : alu_y;

  alu_param #(.DATA_W(DATA_W)) u_alu (
    .op_i (op),
    .a_i  (regs_q[ra]),
    .b_i  (regs_q[rb]),
    .y_o  (alu_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      result_q   <= '0;
      last_rd_q  <= '0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      result_q   <= result_d;
      last_rd_q  <= last_rd_d;
      btn_prev_q <= next_inst;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    result_d  = result_q;
    last_rd_d = last_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_rise || run_mode) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_d    = imem_q[pc_q];
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (writes_reg) begin
          result_d  = wb_data;
          last_rd_d = rd;
        end
        if (op == OP_HALT) begin
          state_d = ST_HALTED;
        end else begin
          pc_d    = (op == OP_JNZ && regs_q[rd] != '0) ? IMEM_AW'(imm) : pc_q + 1'b1;
          state_d = run_mode ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (btn_rise) begin
          pc_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Board loads only land while idle/halted, so they never collide with an EXEC writeback.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (load_ok && load_to_reg_file) regs_q[external_reg_file_index] <= external_reg_file_data;
      if (wb_en) regs_q[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok && load_to_inst_mem) imem_q[ext_inst_addr] <= external;
  end

  always_comb begin
    busy        = (state_q == ST_FETCH) || (state_q == ST_EXEC);
    halted      = (state_q == ST_HALTED);
    pc          = pc_q;
    display_out = '0;
    if (is_external) begin
      display_out[0] = 4'(regs_q[external_reg_file_index]);
      display_out[1] = 4'(regs_q[external_reg_file_index] >> 4);
      display_out[2] = 4'(external_reg_file_index);
    end else begin
      display_out[0] = 4'(result_q);
      display_out[1] = 4'(result_q >> 4);
      display_out[2] = 4'(last_rd_q);
    end
    display_out[3] = 4'(pc_q);
  end

endmodule

// File: tb/tb_cpu_controller_param.sv
// tb/tb_cpu_controller_param.sv - self-checking bench for cpu_controller_param (DATA_W=8)
module tb_cpu_controller_param;

  logic            clk = 1'b0;
  logic            reset;
  logic [11:0]     external;
  logic [2:0]      ext_inst_addr;
  logic [7:0]      ext_data;
  logic [2:0]      ext_idx;
  logic            is_external, load_to_inst_mem, load_to_reg_file, next_inst, run_mode;
  logic            busy, halted;
  logic [2:0]      pc;
  logic [3:0][3:0] display_out;

  always #5 clk = ~clk;

  cpu_controller_param #(.DATA_W(8), .RIDX_W(3), .IMEM_AW(3)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .external                (external),
    .ext_inst_addr           (ext_inst_addr),
    .external_reg_file_data  (ext_data),
    .external_reg_file_index (ext_idx),
    .is_external             (is_external),
    .load_to_inst_mem        (load_to_inst_mem),
    .load_to_reg_file        (load_to_reg_file),
    .next_inst               (next_inst),
    .run_mode                (run_mode),
    .busy                    (busy),
    .halted                  (halted),
    .pc                      (pc),
    .display_out             (display_out)
  );

  logic [11:0] imem_m [8];
  logic [7:0]  regs_m [8];
  logic [7:0]  result_m;
  int          pc_m, rd_m;
  bit          busy_m, halted_m, cmp_en;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_disp();
    logic [7:0] v;
    logic [3:0] mid;
    if (is_external) begin
      v   = regs_m[ext_idx];
      mid = {1'b0, ext_idx};
    end else begin
      v   = result_m;
      mid = rd_m[3:0];
    end
    return {pc_m[3:0], mid, v};
  endfunction

  // Architectural effect of one instruction at pc_m.
  task automatic exec_model();
    int w, op, rd, ra, rb, imm, a, b, v;
    bit wr;
    w   = int'(imem_m[pc_m]);
    op  = w / 512;
    rd  = (w / 64) % 8;
    ra  = (w / 8) % 8;
    rb  = w % 8;
    imm = ra * 8 + rb;
    a   = int'(regs_m[ra]);
    b   = int'(regs_m[rb]);
    wr  = 1'b1;
    v   = 0;
    case (op)
      1:       v = imm % 256;
      2:       v = (a + b) % 256;
      3:       v = (a - b + 256) % 256;
      4:       v = a & b;
      5:       v = a | b;
      default: wr = 1'b0;
    endcase
    if (wr) begin
      regs_m[rd] = 8'(v);
      result_m   = 8'(v);
      rd_m       = rd;
    end
    if (op == 7) halted_m = 1'b1;
    else if (op == 6 && regs_m[rd] != 8'd0) pc_m = imm % 8;
    else pc_m = (pc_m + 1) % 8;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc", 32'(pc), 32'(pc_m));
      check("busy", 32'(busy), 32'(busy_m));
      check("halted", 32'(halted), 32'(halted_m));
      check("display", 32'(display_out), 32'(exp_disp()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_reg(input int idx, input int val);
    ext_idx = 3'(idx);
    ext_data = 8'(val);
    load_to_reg_file = 1'b1;
    tick();
    regs_m[idx] = 8'(val);
    load_to_reg_file = 1'b0;
  endtask

  task automatic load_inst(input int addr, input logic [11:0] w);
    ext_inst_addr = 3'(addr);
    external = w;
    load_to_inst_mem = 1'b1;
    tick();
    imem_m[addr] = w;
    load_to_inst_mem = 1'b0;
  endtask

  task automatic press(input int hold);
    next_inst = 1'b1;
    tick();
    busy_m = 1'b1;
    tick();
    tick();
    busy_m = 1'b0;
    exec_model();
    repeat (hold) tick();
    next_inst = 1'b0;
    tick();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) regs_m[i] = 8'd0;
    pc_m = 0;
    rd_m = 0;
    result_m = 8'd0;
    busy_m = 1'b0;
    halted_m = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    external = '0;
    ext_inst_addr = '0;
    ext_data = '0;
    ext_idx = '0;
    is_external = 1'b0;
    load_to_inst_mem = 1'b0;
    load_to_reg_file = 1'b0;
    next_inst = 1'b0;
    run_mode = 1'b0;
    cmp_en = 1'b0;
    model_reset();
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_display", 32'(display_out), 32'h0);
    reset = 1'b1;
    cmp_en = 1'b1;

    // Both load strobes together, then ADD r2,r0,r1 with a latency probe.
    ext_inst_addr = 3'd0;
    external = 12'b010_010_000_001;
    load_to_inst_mem = 1'b1;
    ext_idx = 3'd0;
    ext_data = 8'd1;
    load_to_reg_file = 1'b1;
    tick();
    imem_m[0] = 12'b010_010_000_001;
    regs_m[0] = 8'd1;
    load_to_inst_mem = 1'b0;
    load_to_reg_file = 1'b0;
    load_reg(1, 2);
    next_inst = 1'b1;
    tick();
    busy_m = 1'b1;
    tick();
    check("latency_exec_display", 32'(display_out), 32'h0);
    tick();
    busy_m = 1'b0;
    exec_model();
    check("add_display", 32'(display_out), 32'h1203);
    next_inst = 1'b0;
    tick();

    // Held button: exactly one step.
    load_inst(1, 12'h000);
    press(17);
    check("held_pc", 32'(pc), 32'd2);

    // Loads during FETCH/EXEC must be dropped.
    load_inst(2, 12'b010_011_000_001);
    load_inst(3, 12'b010_100_000_001);
    next_inst = 1'b1;
    tick();
    busy_m = 1'b1;
    ext_idx = 3'd0;
    ext_data = 8'hAA;
    load_to_reg_file = 1'b1;
    ext_inst_addr = 3'd3;
    external = 12'hE00;
    load_to_inst_mem = 1'b1;
    tick();
    tick();
    busy_m = 1'b0;
    exec_model();
    load_to_reg_file = 1'b0;
    load_to_inst_mem = 1'b0;
    next_inst = 1'b0;
    tick();
    is_external = 1'b1;
    ext_idx = 3'd0;
    tick();
    check("busy_load_r0", 32'(display_out), 32'h3001);
    is_external = 1'b0;

    // 8-bit wraparound and remaining ops; pc wraps 7 -> 0.
    load_reg(0, 255);
    load_reg(1, 1);
    press(0);
    check("wrap_add", 32'(display_out), 32'h4400);
    load_inst(4, 12'b011_101_100_001);
    load_inst(5, 12'b001_111_101_100);
    load_inst(6, 12'b101_110_111_001);
    load_inst(7, 12'b100_110_110_010);
    press(0);
    check("sub_wrap", 32'(display_out), 32'h55FF);
    press(0);
    press(0);
    press(0);
    check("pc_wrap", 32'(pc), 32'd0);
    check("and_display", 32'(display_out), 32'h0601);

    // Countdown loop in run mode until HALT.
    load_inst(0, 12'b001_000_000_011);
    load_inst(1, 12'b011_000_000_001);
    load_inst(2, 12'b110_000_000_001);
    load_inst(3, 12'b111_000_000_000);
    for (int i = 0; i < 64 && !halted_m; i++) exec_model();
    cmp_en = 1'b0;
    run_mode = 1'b1;
    for (int i = 0; i < 200 && !halted; i++) tick();
    check("run_halted", 32'(halted), 32'd1);
    run_mode = 1'b0;
    tick();
    cmp_en = 1'b1;
    check("loop_pc", 32'(pc), 32'd3);
    is_external = 1'b1;
    ext_idx = 3'd0;
    tick();
    check("loop_r0", 32'(display_out), 32'h3000);
    is_external = 1'b0;

    next_inst = 1'b1;
    tick();
    pc_m = 0;
    halted_m = 1'b0;
    next_inst = 1'b0;
    tick();
    check("unhalt_pc", 32'(pc), 32'd0);
    check("unhalt_halted", 32'(halted), 32'd0);

    // Endless loop, then asynchronous reset mid-run.
    load_inst(3, 12'b110_001_000_000);
    cmp_en = 1'b0;
    run_mode = 1'b1;
    repeat (7) tick();
    check("running_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midrun_reset_busy", 32'(busy), 32'd0);
    check("midrun_reset_pc", 32'(pc), 32'd0);
    check("midrun_reset_display", 32'(display_out), 32'h0);
    is_external = 1'b1;
    ext_idx = 3'd0;
    #1;
    check("midrun_reset_r0", 32'(display_out), 32'h0);
    run_mode = 1'b0;
    tick();
    reset = 1'b1;
    is_external = 1'b0;
    model_reset();
    tick();
    cmp_en = 1'b1;
    press(0);
    check("imem_kept", 32'(display_out), 32'h1003);

    tick();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
